// File: rtl/counter_pkg.sv
// Shared constants for the free-running modulo counter.
// Holds the default count width used by counter.
package counter_pkg;

  localparam int COUNTER_WIDTH = 4;

endpackage

// File: rtl/counter.sv
// Modulo (MAX_VALUE+1) up-counter with terminal-count flag; count updates on the same edge, tc is combinational.
// No flow control: counts every cycle unless held in synchronous reset.
module counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = COUNTER_WIDTH,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_CNT = MAX_VALUE[WIDTH-1:0];

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter: WIDTH must be in 1..32");
    end
    if (MAX_VALUE < 64'd1 || MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("counter: MAX_VALUE must be in 1..2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] count_next;

  // >= also recovers from any out-of-range value by loading 0.
  always_comb begin
    count_next = count + WIDTH'(1);
    if (count >= MAX_CNT) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign tc = (count == MAX_CNT);

`ifndef SYNTHESIS
  logic rst_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_seen <= 1'b1;
    end
  end

  a_range : assert property (@(posedge clk) (rst_seen && !reset) |-> (count <= MAX_CNT))
    else $error("counter: count above MAX_VALUE after reset");
  a_wrap : assert property (@(posedge clk) (rst_seen && !reset && count == MAX_CNT) |=> (count == '0))
    else $error("counter: no wrap after MAX_VALUE");
  a_reset : assert property (@(posedge clk) reset |=> (count == '0))
    else $error("counter: reset did not clear count");
`endif

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: default instance (mod 16) and a WIDTH=3/MAX_VALUE=5 variant (mod 6).
module tb_counter;

  logic       clk;
  logic       reset;
  logic [3:0] count_a;
  logic       tc_a;
  logic [2:0] count_b;
  logic       tc_b;

  int total;
  int bad;
  int m_a;
  int m_b;
  int tc_seen;

  typedef struct {
    logic [3:0] ca;
    logic       ta;
    logic [2:0] cb;
    logic       tb;
  } exp_t;

  exp_t sb[$];

  counter dut_a (
    .clk   (clk),
    .reset (reset),
    .count (count_a),
    .tc    (tc_a)
  );

  counter #(
    .WIDTH     (3),
    .MAX_VALUE (5)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .count (count_b),
    .tc    (tc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive reset, push the model's expectation, then pop and compare just after the edge.
  task automatic step(input logic r);
    exp_t e;
    reset = r;
    m_a = r ? 0 : ((m_a >= 15) ? 0 : m_a + 1);
    m_b = r ? 0 : ((m_b >= 5) ? 0 : m_b + 1);
    e.ca = m_a[3:0];
    e.ta = (m_a == 15);
    e.cb = m_b[2:0];
    e.tb = (m_b == 5);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count_a", 32'(count_a), 32'(e.ca));
    chk("tc_a", 32'(tc_a), 32'(e.ta));
    chk("count_b", 32'(count_b), 32'(e.cb));
    chk("tc_b", 32'(tc_b), 32'(e.tb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    m_a = 0;
    m_b = 0;
    reset = 1'b1;

    // Power-up: reset high until 12 ns, count 0 at 5 ns and 1 at 15 ns.
    step(1'b1);
    chk("pwr_0", 32'(count_a), 0);
    #6;
    step(1'b0);
    chk("pwr_1", 32'(count_a), 1);

    // Free run to 105 ns with tc low.
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0);
      tc_seen += int'(tc_a);
    end
    chk("t105", 32'(count_a), 10);
    chk("free_tc", 32'(tc_seen), 0);

    // Wrap: 22 more edges pass 15 twice and end on 0.
    tc_seen = 0;
    for (int i = 0; i < 22; i++) begin
      step(1'b0);
      tc_seen += int'(tc_a);
    end
    chk("wrap_tc_cnt", 32'(tc_seen), 2);
    chk("wrap_end", 32'(count_a), 0);

    // Mid-count reset at 7.
    for (int i = 0; i < 20 && m_a != 7; i++) step(1'b0);
    chk("reach7", 32'(count_a), 7);
    step(1'b1);
    chk("mid_rst", 32'(count_a), 0);
    step(1'b0);
    chk("mid_rel", 32'(count_a), 1);

    // Reset on the terminal count: no extra tc before the next natural 15.
    for (int i = 0; i < 20 && m_a != 15; i++) step(1'b0);
    chk("term_tc", 32'(tc_a), 1);
    step(1'b1);
    chk("term_rst", 32'(count_a), 0);
    chk("term_rst_tc", 32'(tc_a), 0);
    step(1'b1);
    chk("hold_rst", 32'(count_a), 0);
    step(1'b0);
    chk("term_rel", 32'(count_a), 1);
    tc_seen = 0;
    for (int i = 0; i < 13; i++) begin
      step(1'b0);
      tc_seen += int'(tc_a);
    end
    chk("no_dup_tc", 32'(tc_seen), 0);
    step(1'b0);
    chk("next_tc", 32'(tc_a), 1);

    // Variant: mod-6 sequence, tc only at 5.
    step(1'b1);
    tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      tc_seen += int'(tc_b);
    end
    chk("var_tc_cnt", 32'(tc_seen), 2);
    chk("var_end", 32'(count_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, setting the count width in bits (legal range 1..32).
REQ-002 The module SHALL have parameter MAX_VALUE, default 2**WIDTH-1, setting the terminal count value (legal range 1..2**WIDTH-1).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port count, output, WIDTH bits: current counter value, driven directly from a register.
REQ-006 Port tc, output, 1 bit: terminal-count flag, high while count == MAX_VALUE; may be left unconnected.

Function
REQ-007 On each rising clk edge with reset low, count SHALL become count+1 when count < MAX_VALUE.
REQ-008 On a rising clk edge with reset low and count == MAX_VALUE, count SHALL wrap to 0.
REQ-009 With defaults, the sequence SHALL be 0,1,...,15,0,1,... with a period of 16 cycles.
REQ-010 Latency: count SHALL change on the same rising edge that samples reset low, with no extra pipeline stage.
REQ-011 tc SHALL be combinational from the count register only, with no dependency on reset.
REQ-012 tc SHALL be high for exactly one cycle per wrap period when counting freely.
REQ-013 Arithmetic SHALL be unsigned, modulo MAX_VALUE+1.
REQ-014 No intermediate result SHALL need more than WIDTH bits.
REQ-015 If count ever holds a value > MAX_VALUE (not reachable in normal operation), the next non-reset edge SHALL load 0.

Reset
REQ-016 When reset is high at a rising clk edge, count SHALL become 0 and tc SHALL follow that count.
REQ-017 Reset SHALL take priority over counting, including on the wrap edge.
REQ-018 Reset asserted mid-count SHALL force count to 0 at the next rising edge, regardless of the current value.
REQ-019 Count SHALL stay 0 for every edge on which reset remains high.
REQ-020 Deasserting reset SHALL produce count = 1 on the first rising edge that samples reset low.
REQ-021 Before the first rising edge with reset high, count is undefined.
REQ-022 Users SHALL hold reset high for at least one rising edge after power-up.
REQ-023 The reset SHALL be purely synchronous: reset SHALL NOT appear in any sensitivity list.

Structure
REQ-024 A shared package counter_pkg SHALL hold the default width constant COUNTER_WIDTH = 4.
REQ-025 The module's WIDTH parameter SHALL default to COUNTER_WIDTH from counter_pkg.
REQ-026 The implementation SHALL be a single module with one count register, next-state logic and the tc compare.
REQ-027 The module SHALL NOT contain sub-modules.
REQ-028 The module SHALL include elaboration-time parameter checks that reject an illegal WIDTH or MAX_VALUE.
REQ-029 The module SHALL include simulation-only assertions for: count <= MAX_VALUE after reset; a wrap after MAX_VALUE; reset-to-zero.

Verification
REQ-030 Power-up: clk period 10 ns starting low; reset high 0-12 ns, then low -> count = 0 at 5 ns and 1 at 15 ns.
REQ-031 Free run for 100 ns after reset release -> count increments by 1 per edge, reaching 10 at 105 ns; tc stays low throughout.
REQ-032 Wrap: run 16+ cycles from 0 -> count 15 with tc = 1 for one cycle, then 0 with tc = 0.
REQ-033 Mid-count reset: assert reset for 1 cycle while count = 7 -> next edge gives count = 0, and the following edge gives 1.
REQ-034 Reset at terminal: assert reset while count = 15 -> count = 0, not a wrap-by-increment; no duplicate tc pulse.
REQ-035 Parameter variant WIDTH = 3, MAX_VALUE = 5 -> sequence 0..5,0; tc high only at 5.
